// File: rtl/ap_perf_pkg.sv
// Shared types and defaults for the ap_ctrl performance monitor.
// The per-channel FSM encoding is visible on the packed ch_state output,
// so the enum values are fixed: IDLE=0, BUSY=1, DONE_WAIT=2.
package ap_perf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_t;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_CNT_W  = 32;

endpackage

// File: rtl/ap_ctrl_chan_tracker.sv
// One ap_ctrl channel: handshake FSM, latency counter and statistics.
// Optional feature macro: AP_PERF_MAX_LAT_EN adds a running maximum of the
// captured latencies (max_latency port exists only in that build).
// All statistics saturate at all-ones and stop updating while 'frozen' is
// high; the FSM and the latency counter keep tracking regardless.
module ap_ctrl_chan_tracker
  import ap_perf_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frozen,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
`ifdef AP_PERF_MAX_LAT_EN
  output logic [CNT_W-1:0] max_latency,
`endif
  output logic [1:0]       state,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] last_latency
);

  ch_state_t        cur_state;
  ch_state_t        next_state;
  logic             capture;
  logic             lat_load;
  logic [CNT_W-1:0] lat_count;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign state = cur_state;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= next_state;
  end

  // Next-state logic; a done in BUSY is the only event that records a transaction.
  always_comb begin
    next_state = cur_state;
    capture    = 1'b0;
    lat_load   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (ap_start) begin
          next_state = BUSY;
          lat_load   = 1'b1;
        end
      end
      BUSY: begin
        if (ap_done) begin
          capture = 1'b1;
          if (!ap_continue) begin
            next_state = DONE_WAIT;
          end else if (ap_start) begin
            next_state = BUSY;
            lat_load   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DONE_WAIT: begin
        if (ap_continue) begin
          if (ap_start) begin
            next_state = BUSY;
            lat_load   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter: reads k in the k-th BUSY cycle after the start was sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  lat_count <= '0;
    else if (lat_load)          lat_count <= CNT_W'(1);
    else if (cur_state == BUSY) lat_count <= sat_inc(lat_count);
  end

  // Statistics update, suppressed once the monitor is frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_count    <= '0;
      busy_cycles  <= '0;
      stall_cycles <= '0;
      last_latency <= '0;
    end else if (!frozen) begin
      if (capture) begin
        txn_count    <= sat_inc(txn_count);
        last_latency <= lat_count;
      end
      if (cur_state == BUSY)      busy_cycles  <= sat_inc(busy_cycles);
      if (cur_state == DONE_WAIT) stall_cycles <= sat_inc(stall_cycles);
    end
  end

`ifdef AP_PERF_MAX_LAT_EN
  // Running maximum of captured latencies, also subject to freeze.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_latency <= '0;
    end else if (!frozen && capture && (lat_count > max_latency)) begin
      max_latency <= lat_count;
    end
  end
`endif

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for NUM_CH ap_ctrl handshake channels.
// Optional feature macro: AP_PERF_MAX_LAT_EN enables per-channel maximum
// latency tracking; without it rd_max_latency is constant zero.
// 'finish' sets a sticky freeze one cycle later; only reset clears it.
// Readout is registered: rd_* shows channel rd_ch one cycle after sampling,
// and any rd_ch at or above NUM_CH reads as zeros.
module ap_ctrl_perf_monitor
  import ap_perf_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                finish,
  input  logic [NUM_CH-1:0]   ap_start,
  input  logic [NUM_CH-1:0]   ap_done,
  input  logic [NUM_CH-1:0]   ap_continue,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [2*NUM_CH-1:0] ch_state,
  output logic [CNT_W-1:0]    rd_txn_count,
  output logic [CNT_W-1:0]    rd_busy_cycles,
  output logic [CNT_W-1:0]    rd_stall_cycles,
  output logic [CNT_W-1:0]    rd_last_latency,
  output logic [CNT_W-1:0]    rd_max_latency,
  output logic                frozen
);

  logic [CNT_W-1:0] txn_arr   [NUM_CH];
  logic [CNT_W-1:0] busy_arr  [NUM_CH];
  logic [CNT_W-1:0] stall_arr [NUM_CH];
  logic [CNT_W-1:0] last_arr  [NUM_CH];
  logic [CNT_W-1:0] sel_txn;
  logic [CNT_W-1:0] sel_busy;
  logic [CNT_W-1:0] sel_stall;
  logic [CNT_W-1:0] sel_last;
`ifdef AP_PERF_MAX_LAT_EN
  logic [CNT_W-1:0] max_arr   [NUM_CH];
  logic [CNT_W-1:0] sel_max;
`endif

  // Sticky freeze flag; a done sampled with finish is still recorded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_chan_tracker #(
      .CNT_W (CNT_W)
    ) u_tracker (
      .clock        (clock),
      .reset        (reset),
      .frozen       (frozen),
      .ap_start     (ap_start[g]),
      .ap_done      (ap_done[g]),
      .ap_continue  (ap_continue[g]),
`ifdef AP_PERF_MAX_LAT_EN
      .max_latency  (max_arr[g]),
`endif
      .state        (ch_state[2*g +: 2]),
      .txn_count    (txn_arr[g]),
      .busy_cycles  (busy_arr[g]),
      .stall_cycles (stall_arr[g]),
      .last_latency (last_arr[g])
    );
  end

  // Readout select; unmatched (out-of-range) channel numbers give zeros.
  always_comb begin
    sel_txn   = '0;
    sel_busy  = '0;
    sel_stall = '0;
    sel_last  = '0;
`ifdef AP_PERF_MAX_LAT_EN
    sel_max   = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        sel_txn   = txn_arr[i];
        sel_busy  = busy_arr[i];
        sel_stall = stall_arr[i];
        sel_last  = last_arr[i];
`ifdef AP_PERF_MAX_LAT_EN
        sel_max   = max_arr[i];
`endif
      end
    end
  end

  // Registered readout of the selected channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_txn_count    <= '0;
      rd_busy_cycles  <= '0;
      rd_stall_cycles <= '0;
      rd_last_latency <= '0;
    end else begin
      rd_txn_count    <= sel_txn;
      rd_busy_cycles  <= sel_busy;
      rd_stall_cycles <= sel_stall;
      rd_last_latency <= sel_last;
    end
  end

`ifdef AP_PERF_MAX_LAT_EN
  // Registered readout of the selected channel's maximum latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_max_latency <= '0;
    else       rd_max_latency <= sel_max;
  end
`else
  assign rd_max_latency = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed self-checking bench for ap_ctrl_perf_monitor.
// Built with NUM_CH=4, CNT_W=4 (to reach saturation quickly) and CH_W=3 so
// that out-of-range readout channels can be addressed.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ap_ctrl_perf_monitor;

  logic       clock;
  logic       reset;
  logic       finish;
  logic [3:0] ap_start;
  logic [3:0] ap_done;
  logic [3:0] ap_continue;
  logic [2:0] rd_ch;
  logic [7:0] ch_state;
  logic [3:0] rd_txn_count;
  logic [3:0] rd_busy_cycles;
  logic [3:0] rd_stall_cycles;
  logic [3:0] rd_last_latency;
  logic [3:0] rd_max_latency;
  logic       frozen;

  int errors = 0;
  int checks = 0;

  ap_ctrl_perf_monitor #(
    .NUM_CH (4),
    .CNT_W  (4),
    .CH_W   (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .finish          (finish),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_continue     (ap_continue),
    .rd_ch           (rd_ch),
    .ch_state        (ch_state),
    .rd_txn_count    (rd_txn_count),
    .rd_busy_cycles  (rd_busy_cycles),
    .rd_stall_cycles (rd_stall_cycles),
    .rd_last_latency (rd_last_latency),
    .rd_max_latency  (rd_max_latency),
    .frozen          (frozen)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs; returns on the next falling edge.
  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] d,
                               input logic [3:0] c, input logic f);
    ap_start    = s;
    ap_done     = d;
    ap_continue = c;
    finish      = f;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    finish      = 1'b0;
    ap_start    = 4'h0;
    ap_done     = 4'h0;
    ap_continue = 4'hF;
    rd_ch       = 3'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ch_state !== 8'h00) begin errors++; $display("[TB] FAIL reset_ch_state got=%0h exp=0", ch_state); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL reset_frozen got=%0b exp=0", frozen); end
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_txn got=%0d exp=0", rd_txn_count); end
    checks++; if (rd_busy_cycles !== 4'd0) begin errors++; $display("[TB] FAIL reset_busy got=%0d exp=0", rd_busy_cycles); end
    checks++; if (rd_last_latency !== 4'd0) begin errors++; $display("[TB] FAIL reset_last got=%0d exp=0", rd_last_latency); end
  endtask

  // ch0: start, four idle BUSY cycles, done with continue -> latency 5.
  task automatic test_single();
    do_reset();
    rd_ch = 3'd0;
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    checks++; if (ch_state[1:0] !== 2'd1) begin errors++; $display("[TB] FAIL single_busy got=%0d exp=1", ch_state[1:0]); end
    repeat (4) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    checks++; if (ch_state[1:0] !== 2'd0) begin errors++; $display("[TB] FAIL single_idle got=%0d exp=0", ch_state[1:0]); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_last_latency !== 4'd5) begin errors++; $display("[TB] FAIL single_last got=%0d exp=5", rd_last_latency); end
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL single_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_busy_cycles !== 4'd5) begin errors++; $display("[TB] FAIL single_busy_cycles got=%0d exp=5", rd_busy_cycles); end
    checks++; if (rd_stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL single_stall got=%0d exp=0", rd_stall_cycles); end
  endtask

  // ch1: done with continue low, three DONE_WAIT cycles; done/start ignored there.
  task automatic test_stall();
    do_reset();
    rd_ch = 3'd1;
    applyStimulus(4'b0010, 4'b0000, 4'b1101, 1'b0);
    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b1101, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 4'b1101, 1'b0);
    checks++; if (ch_state[3:2] !== 2'd2) begin errors++; $display("[TB] FAIL stall_done_wait got=%0d exp=2", ch_state[3:2]); end
    applyStimulus(4'b0000, 4'b0010, 4'b1101, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 4'b1101, 1'b0);
    checks++; if (ch_state[3:2] !== 2'd2) begin errors++; $display("[TB] FAIL stall_start_ignored got=%0d exp=2", ch_state[3:2]); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (ch_state[3:2] !== 2'd0) begin errors++; $display("[TB] FAIL stall_idle got=%0d exp=0", ch_state[3:2]); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_last_latency !== 4'd4) begin errors++; $display("[TB] FAIL stall_last got=%0d exp=4", rd_last_latency); end
    checks++; if (rd_stall_cycles !== 4'd3) begin errors++; $display("[TB] FAIL stall_cycles got=%0d exp=3", rd_stall_cycles); end
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL stall_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_busy_cycles !== 4'd4) begin errors++; $display("[TB] FAIL stall_busy got=%0d exp=4", rd_busy_cycles); end
  endtask

  // ch2: done+continue+start restarts without leaving BUSY.
  task automatic test_back_to_back();
    do_reset();
    rd_ch = 3'd2;
    applyStimulus(4'b0100, 4'b0000, 4'hF, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 4'hF, 1'b0);
    checks++; if (ch_state[5:4] !== 2'd1) begin errors++; $display("[TB] FAIL b2b_still_busy got=%0d exp=1", ch_state[5:4]); end
    repeat (2) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 4'hF, 1'b0);
    checks++; if (ch_state[5:4] !== 2'd0) begin errors++; $display("[TB] FAIL b2b_idle got=%0d exp=0", ch_state[5:4]); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd2) begin errors++; $display("[TB] FAIL b2b_txn got=%0d exp=2", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd3) begin errors++; $display("[TB] FAIL b2b_last got=%0d exp=3", rd_last_latency); end
    checks++; if (rd_busy_cycles !== 4'd6) begin errors++; $display("[TB] FAIL b2b_busy got=%0d exp=6", rd_busy_cycles); end
    applyStimulus(4'b0000, 4'b0100, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd2) begin errors++; $display("[TB] FAIL idle_done_ignored got=%0d exp=2", rd_txn_count); end
  endtask

  // ch0 busy 20 cycles saturates 4-bit counters; then finish freezes stats.
  task automatic test_saturate_freeze();
    do_reset();
    rd_ch = 3'd0;
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    repeat (19) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_busy_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_busy got=%0d exp=15", rd_busy_cycles); end
    checks++; if (rd_last_latency !== 4'd15) begin errors++; $display("[TB] FAIL sat_last got=%0d exp=15", rd_last_latency); end
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL sat_txn got=%0d exp=1", rd_txn_count); end
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL freeze_early got=%0b exp=0", frozen); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b1);
    checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL freeze_set got=%0b exp=1", frozen); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    checks++; if (ch_state[1:0] !== 2'd0) begin errors++; $display("[TB] FAIL freeze_fsm_tracks got=%0d exp=0", ch_state[1:0]); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL freeze_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd15) begin errors++; $display("[TB] FAIL freeze_last got=%0d exp=15", rd_last_latency); end
    checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL freeze_sticky got=%0b exp=1", frozen); end
    rd_ch = 3'd1;
    applyStimulus(4'b0010, 4'b0000, 4'b1101, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 4'b1101, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0000, 4'b1101, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL freeze_stall got=%0d exp=0", rd_stall_cycles); end
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL freeze_ch1_txn got=%0d exp=0", rd_txn_count); end
  endtask

  // ch3: done sampled together with finish is still recorded.
  task automatic test_finish_same_cycle();
    do_reset();
    rd_ch = 3'd3;
    applyStimulus(4'b1000, 4'b0000, 4'hF, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 4'hF, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL fin_done_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd3) begin errors++; $display("[TB] FAIL fin_done_last got=%0d exp=3", rd_last_latency); end
    checks++; if (rd_busy_cycles !== 4'd3) begin errors++; $display("[TB] FAIL fin_done_busy got=%0d exp=3", rd_busy_cycles); end
    applyStimulus(4'b1000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL fin_after_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd3) begin errors++; $display("[TB] FAIL fin_after_last got=%0d exp=3", rd_last_latency); end
  endtask

  // ch3: asynchronous reset in the middle of a transaction discards it.
  task automatic test_reset_mid_busy();
    do_reset();
    rd_ch = 3'd3;
    applyStimulus(4'b1000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 4'hF, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 4'hF, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL rmb_pre_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (ch_state[7:6] !== 2'd1) begin errors++; $display("[TB] FAIL rmb_pre_busy got=%0d exp=1", ch_state[7:6]); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL rmb_txn got=%0d exp=0", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd0) begin errors++; $display("[TB] FAIL rmb_last got=%0d exp=0", rd_last_latency); end
    checks++; if (rd_busy_cycles !== 4'd0) begin errors++; $display("[TB] FAIL rmb_busy got=%0d exp=0", rd_busy_cycles); end
    checks++; if (ch_state !== 8'h00) begin errors++; $display("[TB] FAIL rmb_state got=%0h exp=0", ch_state); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL rmb_frozen got=%0b exp=0", frozen); end
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b1000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL rmb_discard_txn got=%0d exp=0", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd0) begin errors++; $display("[TB] FAIL rmb_discard_last got=%0d exp=0", rd_last_latency); end
  endtask

  // Readout is registered and out-of-range channels read zero.
  task automatic test_out_of_range();
    do_reset();
    rd_ch = 3'd0;
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL oor_pre_txn got=%0d exp=1", rd_txn_count); end
    checks++; if (rd_last_latency !== 4'd1) begin errors++; $display("[TB] FAIL oor_pre_last got=%0d exp=1", rd_last_latency); end
    rd_ch = 3'd4;
    #1;
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL oor_registered got=%0d exp=1", rd_txn_count); end
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL oor4_txn got=%0d exp=0", rd_txn_count); end
    checks++; if (rd_busy_cycles !== 4'd0) begin errors++; $display("[TB] FAIL oor4_busy got=%0d exp=0", rd_busy_cycles); end
    checks++; if (rd_last_latency !== 4'd0) begin errors++; $display("[TB] FAIL oor4_last got=%0d exp=0", rd_last_latency); end
    rd_ch = 3'd7;
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd0) begin errors++; $display("[TB] FAIL oor7_txn got=%0d exp=0", rd_txn_count); end
    rd_ch = 3'd0;
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_txn_count !== 4'd1) begin errors++; $display("[TB] FAIL oor_back_txn got=%0d exp=1", rd_txn_count); end
  endtask

  // ch0 latencies 7 then 3: maximum is 7 when the feature is built in, else 0.
  task automatic test_max_latency();
    logic [3:0] exp_max;
`ifdef AP_PERF_MAX_LAT_EN
    exp_max = 4'd7;
`else
    exp_max = 4'd0;
`endif
    do_reset();
    rd_ch = 3'd0;
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    repeat (6) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'hF, 1'b0);
    repeat (2) applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'hF, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'hF, 1'b0);
    checks++; if (rd_last_latency !== 4'd3) begin errors++; $display("[TB] FAIL max_last got=%0d exp=3", rd_last_latency); end
    checks++; if (rd_txn_count !== 4'd2) begin errors++; $display("[TB] FAIL max_txn got=%0d exp=2", rd_txn_count); end
    checks++; if (rd_busy_cycles !== 4'd10) begin errors++; $display("[TB] FAIL max_busy got=%0d exp=10", rd_busy_cycles); end
    checks++; if (rd_max_latency !== exp_max) begin errors++; $display("[TB] FAIL max_latency got=%0d exp=%0d", rd_max_latency, exp_max); end
  endtask

  initial begin
    reset       = 1'b1;
    finish      = 1'b0;
    ap_start    = 4'h0;
    ap_done     = 4'h0;
    ap_continue = 4'hF;
    rd_ch       = 3'd0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_saturate_freeze();
    test_finish_same_cycle();
    test_reset_mid_busy();
    test_out_of_range();
    test_max_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored ap_ctrl channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter and latency field.
REQ-003 SHALL have parameter CH_W, default $clog2(NUM_CH) (min 1), readout index width.
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 finish  input  1  end of test; freezes all statistics.
REQ-007 ap_start  input  NUM_CH  per-channel start.
REQ-008 ap_done  input  NUM_CH  per-channel done.
REQ-009 ap_continue  input  NUM_CH  per-channel continue; tie 1 for ap_ctrl_hs channels.
REQ-010 rd_ch  input  CH_W  readout channel select.
REQ-011 ch_state  output  2*NUM_CH  packed per-channel FSM state.
REQ-012 rd_txn_count, rd_busy_cycles, rd_stall_cycles, rd_last_latency, rd_max_latency  output  CNT_W each  registered readout of channel rd_ch.
REQ-013 frozen  output  1  sticky; statistics frozen.

Function
REQ-014 Each channel SHALL run an FSM: IDLE=0, BUSY=1, DONE_WAIT=2.
REQ-015 IDLE->BUSY when ap_start=1; latency counter loads 1.
REQ-016 BUSY: latency counter +1 per cycle; ap_done=1 captures latency counter into last_latency and increments txn_count.
REQ-017 BUSY on ap_done: ap_continue=1 -> IDLE, or BUSY with latency loaded 1 if ap_start=1 same cycle (back-to-back); ap_continue=0 -> DONE_WAIT.
REQ-018 DONE_WAIT->IDLE when ap_continue=1, or ->BUSY (latency 1) if ap_start=1 same cycle; ap_done ignored while in DONE_WAIT.
REQ-019 ap_done in IDLE SHALL be ignored; ap_start in BUSY/DONE_WAIT SHALL be ignored.
REQ-020 busy_cycles +1 each cycle in BUSY; stall_cycles +1 each cycle in DONE_WAIT.
REQ-021 Start at cycle t, done at cycle t+k SHALL report last_latency=k.
REQ-022 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-023 finish=1 sampled SHALL set frozen=1 next cycle; while frozen, FSMs keep tracking but no statistic updates; frozen clears only on reset.
REQ-024 Finish and ap_done in same cycle: that done's statistics SHALL be recorded (freeze applies from next cycle).
REQ-025 rd_* SHALL reflect rd_ch one cycle after sampling; rd_ch>=NUM_CH returns all zeros.

Reset
REQ-026 Reset SHALL force all FSMs to IDLE, all counters, rd_* outputs and frozen to 0, ch_state to 0, asynchronously.
REQ-027 Reset mid-transaction SHALL discard it; no txn_count or latency recorded.

Configuration
REQ-028 Macro AP_PERF_MAX_LAT_EN defined: per-channel max_latency register updated to max(max_latency, captured latency) on each done, subject to freeze.
REQ-029 Macro undefined: no max_latency storage; rd_max_latency tied 0.

Structure
REQ-030 Package ap_perf_pkg SHALL hold the FSM state enum (2 bits) and default NUM_CH/CNT_W constants.
REQ-031 Sub-module ap_ctrl_chan_tracker SHALL implement one channel's FSM and counters; top instantiates NUM_CH copies, freeze logic and readout mux.

Verification
REQ-032 ch0 start@cycle 10, done+continue@cycle 15 -> rd_last_latency=5, rd_txn_count=1, rd_busy_cycles=5, state IDLE@16.
REQ-033 ch1 start@10, done@14 with continue=0, continue=1@17 -> last_latency=4, stall_cycles=3, state IDLE@18.
REQ-034 ch2 start@10, done+continue+start@13, done+continue@16 -> txn_count=2, last_latency=3, busy_cycles=6 continuous.
REQ-035 CNT_W=4, ch0 busy 20 cycles -> busy_cycles=15 held; finish during later run -> frozen=1, counters unchanged.
REQ-036 Reset asserted mid-BUSY on ch3 -> all rd_*=0 immediately; rd_ch=NUM_CH -> zeros; with AP_PERF_MAX_LAT_EN latencies 7 then 3 -> rd_max_latency=7.
